delay_lines: RTL and testbench

Multi-row line buffer for the stream filter datapath: accepts one pixel stream and presents `LINES` vertically aligned taps, each `cfg_delay` samples (one image row) older than the previous. It generalises the single-row delay into a configurable tap chain with valid/ready flow control and a synchronous reset, feeding column-parallel data to the 2-D filter kernels.

---
 rtl/delay_lines.sv | 137 +++++++++++++
 tb/tb_delay_lines.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/delay_lines.sv
// delay_lines: multi-row line buffer presenting LINES vertically aligned taps.
// Lane 0 is the newest sample; lane k is the sample k*D accepted earlier,
// where D is the row length latched by cfg_set_i.
// Optional feature macro: DELAY_LINES_FILL_EN. When defined, output is valid
// from the first sample after restart and lanes without history read as 0.
// When undefined, warm-up samples are consumed without producing output.

// One row memory: combinational read of the addressed word and a write of
// the same address at the clock edge, giving read-before-write semantics.
module delay_lines_row #(
   parameter int W     = 8,
   parameter int AW    = 12,
   parameter int DEPTH = 1 << AW
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o
);
   logic [W-1:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   // Write on accepted samples only; contents are never cleared.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end
endmodule

module delay_lines #(
   parameter int IMG_WIDTH  = 8,
   parameter int LINES      = 3,
   parameter int MEM_AWIDTH = 12,
   parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [MEM_AWIDTH-1:0]      cfg_delay_i,
   input  logic                       cfg_set_i,
   input  logic [IMG_WIDTH-1:0]       up_data_i,
   input  logic                       up_val_i,
   output logic                       up_rdy_o,
   output logic [LINES*IMG_WIDTH-1:0] dn_data_o,
   output logic                       dn_val_o,
   input  logic                       dn_rdy_i
);
   localparam int AW = MEM_AWIDTH;
   localparam int FW = AW + $clog2(LINES);

   logic [AW-1:0] d_q, d_d, ptr_q, ptr_d;
   logic [FW-1:0] fill_q, fill_d, dext, fill_max;
   logic          full, clr_q, clr_d, dn_val_q, dn_val_d, acc;
   logic [LINES-1:0][IMG_WIDTH-1:0] dn_q, dn_d;
   // rd[0] is the incoming sample, rd[m] the old word read from row m.
   logic [IMG_WIDTH-1:0] rd [LINES];

   assign rd[0] = up_data_i;

   // Chain of row memories: row m stores lane m-1 and yields lane m.
   for (genvar m = 1; m < LINES; m++) begin : g_row
      delay_lines_row #(
         .W    (IMG_WIDTH),
         .AW   (AW),
         .DEPTH(MEM_DEPTH)
      ) u_row (
         .clk_i  (clk_i),
         .we_i   (acc),
         .addr_i (ptr_q),
         .wdata_i(rd[m-1]),
         .rdata_o(rd[m])
      );
   end

   assign dext     = {{(FW-AW){1'b0}}, d_q};
   assign fill_max = FW'(LINES-1) * dext;
   assign full     = (fill_q >= fill_max);

   // Restart blocks input in the cfg_set cycle and the clearing cycle after.
   assign up_rdy_o  = !rst_i && !cfg_set_i && !clr_q && (!dn_val_q || dn_rdy_i);
   assign acc       = up_val_i && up_rdy_o;
   assign dn_data_o = dn_q;
   assign dn_val_o  = dn_val_q;

   // Next-state: restart clear, sample acceptance, or output drain.
   always_comb begin
      ptr_d    = ptr_q;
      fill_d   = fill_q;
      dn_val_d = dn_val_q;
      dn_d     = dn_q;
      d_d      = d_q;
      clr_d    = cfg_set_i;
      if (cfg_set_i) d_d = (cfg_delay_i == '0) ? AW'(1) : cfg_delay_i;
      if (clr_q) begin
         ptr_d    = '0;
         fill_d   = '0;
         dn_val_d = 1'b0;
      end else if (acc) begin
         ptr_d = (ptr_q == d_q - AW'(1)) ? '0 : ptr_q + AW'(1);
         if (!full) fill_d = fill_q + FW'(1);
`ifdef DELAY_LINES_FILL_EN
         dn_val_d = 1'b1;
`else
         dn_val_d = full;
`endif
         for (int k = 0; k < LINES; k++) begin
`ifdef DELAY_LINES_FILL_EN
            // Lane k has history only once k*D samples have been accepted.
            dn_d[k] = (fill_q >= FW'(k) * dext) ? rd[k] : '0;
`else
            dn_d[k] = rd[k];
`endif
         end
      end else if (dn_rdy_i) begin
         dn_val_d = 1'b0;
      end
   end

   // State registers with synchronous reset; D returns to 1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_q      <= AW'(1);
         ptr_q    <= '0;
         fill_q   <= '0;
         clr_q    <= 1'b0;
         dn_val_q <= 1'b0;
         dn_q     <= '0;
      end else begin
         d_q      <= d_d;
         ptr_q    <= ptr_d;
         fill_q   <= fill_d;
         clr_q    <= clr_d;
         dn_val_q <= dn_val_d;
         dn_q     <= dn_d;
      end
   end
endmodule

// File: tb/tb_delay_lines.sv
// Bench for delay_lines (LINES=3, MEM_AWIDTH=4). A sample-history model
// predicts every output word; directed steps follow the block's use cases,
// then a randomized phase mixes stalls, restarts and resets.
module tb_delay_lines;
   localparam int W = 8, L = 3, AW = 4;

   logic          clk = 1'b0;
   logic          rst_i, cfg_set_i, up_val_i, dn_rdy_i;
   logic [AW-1:0] cfg_delay_i;
   logic [W-1:0]  up_data_i;
   logic          up_rdy_o, dn_val_o;
   logic [L*W-1:0] dn_data_o;

   always #5 clk = ~clk;

   delay_lines #(.IMG_WIDTH(W), .LINES(L), .MEM_AWIDTH(AW)) dut (
      .clk_i(clk), .rst_i(rst_i), .cfg_delay_i(cfg_delay_i), .cfg_set_i(cfg_set_i),
      .up_data_i(up_data_i), .up_val_i(up_val_i), .up_rdy_o(up_rdy_o),
      .dn_data_o(dn_data_o), .dn_val_o(dn_val_o), .dn_rdy_i(dn_rdy_i)
   );

   int total = 0, bad = 0;
   // Reference model: row length, restart pending, samples since restart.
   int Dm = 1;
   bit pend = 0;
   int cnt = 0;
   logic [W-1:0]   hist [4096];
   logic [L*W-1:0] expq [$];
   logic [L*W-1:0] got  [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check against model, advance model.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic r,
                      input logic cs, input logic [AW-1:0] cd, input logic rs,
                      output logic acc);
      logic exp_rdy;
      logic [L*W-1:0] e;
      int idx;
      up_val_i = v; up_data_i = d; dn_rdy_i = r;
      cfg_set_i = cs; cfg_delay_i = cd; rst_i = rs;
      #1;
      exp_rdy = !rs && !cs && !pend && (expq.size() == 0 || r);
      chk("up_rdy", 32'(up_rdy_o), 32'(exp_rdy));
      if (!rs) begin
         chk("dn_val", 32'(dn_val_o), 32'(expq.size() != 0));
         if (expq.size() != 0) chk("dn_data", 32'(dn_data_o), 32'(expq[0]));
      end
      if (expq.size() != 0 && r) got.push_back(expq.pop_front());
      acc = v && exp_rdy;
      if (acc) begin
         hist[cnt % 4096] = d;
         e = '0;
         for (int k = 0; k < L; k++) begin
            idx = cnt - k * Dm;
            if (idx >= 0) e[k*W +: W] = hist[idx % 4096];
         end
`ifdef DELAY_LINES_FILL_EN
         expq.push_back(e);
`else
         if (cnt >= (L-1) * Dm) expq.push_back(e);
`endif
         cnt++;
      end
      if (rs) begin
         expq.delete(); cnt = 0; Dm = 1; pend = 0;
      end else begin
         if (pend) begin pend = 0; cnt = 0; expq.delete(); end
         if (cs) begin Dm = (cd == 0) ? 1 : int'(cd); pend = 1; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic r);
      logic a;
      int n;
      a = 0; n = 0;
      while (!a && n < 20) begin
         cyc(1'b1, d, r, 1'b0, '0, 1'b0, a);
         n++;
      end
      if (!a) chk("send_timeout", 32'(a), 32'd1);
   endtask

   task automatic restart(input logic [AW-1:0] cd);
      logic a;
      cyc(1'b0, '0, 1'b1, 1'b1, cd, 1'b0, a);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, a);
      got.delete();
   endtask

   initial begin
      logic a;
      // Reset, then idle reset-state checks.
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, a);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, a);
      chk("rst_dn_data", 32'(dn_data_o), 32'd0);
      chk("rst_dn_val", 32'(dn_val_o), 32'd0);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, a);

      // D=4, samples 0..15 streamed with dn_rdy high.
      restart(4'd4);
      for (int i = 0; i < 16; i++) send(W'(i), 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, a);
      chk("last_out", 32'(got[got.size()-1]), 32'h070B0F);
`ifndef DELAY_LINES_FILL_EN
      chk("out_count", 32'(got.size()), 32'd8);
      chk("first_out", 32'(got[0]), 32'h000408);
`endif

      // Same stream, 3-cycle downstream stall after sample 10's output.
      restart(4'd4);
      for (int i = 0; i < 11; i++) send(W'(i), 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'd11, 1'b0, 1'b0, '0, 1'b0, a);
         chk("stall_hold", 32'(dn_data_o), 32'h02060A);
      end
      for (int i = 11; i < 16; i++) send(W'(i), 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, a);

      // Mid-stream restart to D=2 with up_val held high.
      restart(4'd4);
      for (int i = 0; i < 10; i++) send(W'(i), 1'b1);
      cyc(1'b1, 8'hAA, 1'b1, 1'b1, 4'd2, 1'b0, a);
      cyc(1'b1, 8'hAA, 1'b1, 1'b0, '0, 1'b0, a);
      chk("restart_dn_val", 32'(dn_val_o), 32'd0);
      got.delete();
      for (int i = 0; i < 6; i++) send(W'(i), 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, a);
`ifndef DELAY_LINES_FILL_EN
      chk("d2_first", 32'(got[0]), 32'h000204);
`endif

      // Maximum D=15, 40 random samples across pointer wrap.
      restart(4'd15);
      for (int i = 0; i < 40; i++) send(W'($urandom), 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, a);

      // D=0 behaves as 1, then reset mid-stream.
      restart(4'd0);
      for (int i = 0; i < 10; i++) send(W'($urandom), 1'b1);
      cyc(1'b1, 8'h55, 1'b1, 1'b0, '0, 1'b1, a);
      chk("midrst_dn_val", 32'(dn_val_o), 32'd0);
      for (int i = 0; i < 10; i++) send(W'($urandom), 1'b1);

`ifdef DELAY_LINES_FILL_EN
      // Fill mode: output from the first sample with masked lanes.
      restart(4'd4);
      for (int i = 0; i < 10; i++) send(W'(i), 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, a);
      chk("fill_count", 32'(got.size()), 32'd10);
      if (got.size() >= 9) begin
         chk("fill_s0", 32'(got[0]), 32'h000000);
         chk("fill_s5", 32'(got[5]), 32'h000105);
         chk("fill_s8", 32'(got[8]), 32'h000408);
      end
`endif

      // Randomized traffic with stalls, restarts and rare resets.
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), W'($urandom),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 63) == 0), AW'($urandom),
             1'($urandom_range(0, 499) == 0), a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
